// File: rtl/bcd_adder.sv
// ---------------------------------------------------------------------------
// bcd_adder
//
// Single-digit BCD adder with one registered output stage. Adds two BCD
// digits plus a decimal carry-in and produces one corrected BCD digit and a
// decimal carry-out. Several of these can be chained into a multi-digit
// decimal adder by feeding each finalcarry into the next stage's cin.
// Operands above 9 are flagged on err and produce a zero result.
//
// Ports
//   clk         in   1  system clock, rising edge active
//   rst_n       in   1  asynchronous active-low reset
//   in_valid    in   1  a, b and cin are presented this cycle
//   a           in   4  BCD operand A (legal 0-9)
//   b           in   4  BCD operand B (legal 0-9)
//   cin         in   1  decimal carry-in
//   sum         out  4  registered BCD result digit (0-9)
//   finalcarry  out  1  registered decimal carry-out (weight 10)
//   out_valid   out  1  sum/finalcarry/err hold a new result this cycle
//   err         out  1  registered flag: captured a or b was above 9
//
// Latency is one cycle. With in_valid low, out_valid drops and the result
// registers keep their previous contents.
// ---------------------------------------------------------------------------
module bcd_adder (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       in_valid,
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       cin,
    output logic [3:0] sum,
    output logic       finalcarry,
    output logic       out_valid,
    output logic       err
);

    // -----------------------------------------------------------------------
    // Combinational datapath
    // -----------------------------------------------------------------------
    logic [4:0] w_t;          // binary sum, 0-31, never truncated
    logic       w_a_bad;
    logic       w_b_bad;
    logic       w_operand_bad;
    logic       w_fix;        // binary sum exceeds 9, decimal correction needed
    logic [4:0] w_t_fixed;
    logic [3:0] w_sum_next;
    logic       w_carry_next;

    // Widen every term before adding so the carry out of bit 3 survives.
    assign w_t = {1'b0, a} + {1'b0, b} + {4'b0000, cin};

    // A digit above 9 has bit 3 set together with bit 2 or bit 1.
    assign w_a_bad       = a[3] & (a[2] | a[1]);
    assign w_b_bad       = b[3] & (b[2] | b[1]);
    assign w_operand_bad = w_a_bad | w_b_bad;

    // t > 9: either t >= 16, or t is 10-15 (bit 3 plus bit 2 or bit 1).
    assign w_fix = w_t[4] | (w_t[3] & (w_t[2] | w_t[1]));

    // Adding 6 skips the six unused codes 10-15; only the low nibble is kept.
    assign w_t_fixed = w_t + 5'd6;

    // NOTE: always_comb assigns every output a default first so no path can
    // leave a signal unassigned and infer a latch.
    always_comb begin
        w_sum_next   = w_t[3:0];
        w_carry_next = 1'b0;
        if (w_operand_bad) begin
            // An illegal operand yields no arithmetic result at all.
            w_sum_next   = 4'd0;
            w_carry_next = 1'b0;
        end else if (w_fix) begin
            w_sum_next   = w_t_fixed[3:0];
            w_carry_next = 1'b1;
        end
    end

    // -----------------------------------------------------------------------
    // Output register stage
    // -----------------------------------------------------------------------
    logic [3:0] r_sum;
    logic       r_carry;
    logic       r_err;
    logic       r_valid;

    // NOTE: state registers use non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sum   <= 4'd0;
            r_carry <= 1'b0;
            r_err   <= 1'b0;
            r_valid <= 1'b0;
        end else begin
            r_valid <= in_valid;
            if (in_valid) begin
                r_sum   <= w_sum_next;
                r_carry <= w_carry_next;
                r_err   <= w_operand_bad;
            end
        end
    end

    assign sum        = r_sum;
    assign finalcarry = r_carry;
    assign err        = r_err;
    assign out_valid  = r_valid;

endmodule

// File: tb/tb_bcd_adder.sv
// ---------------------------------------------------------------------------
// tb_bcd_adder
//
// Self-checking bench for bcd_adder. A decimal reference model (plain
// modulo/divide arithmetic) predicts every registered output; directed steps
// cover reset, correction boundaries, an exhaustive back-to-back sweep,
// invalid operands with hold, and a randomized tail.
// ---------------------------------------------------------------------------
module tb_bcd_adder;

    logic       clk;
    logic       rst_n;
    logic       in_valid;
    logic [3:0] a;
    logic [3:0] b;
    logic       cin;
    logic [3:0] sum;
    logic       finalcarry;
    logic       out_valid;
    logic       err;

    int n_cmp = 0;
    int n_err = 0;

    // Reference model state: what the outputs should currently show.
    int exp_sum   = 0;
    int exp_carry = 0;
    int exp_err   = 0;
    int exp_valid = 0;

    bcd_adder dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .a          (a),
        .b          (b),
        .cin        (cin),
        .sum        (sum),
        .finalcarry (finalcarry),
        .out_valid  (out_valid),
        .err        (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Global time limit so the run always ends.
    initial begin
        #2_000_000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "simulation time limit reached");
    end

    task automatic check(input string tag, input int obs, input int expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
        end
    endtask

    task automatic check_outputs(input string tag);
        check({tag, ".sum"},        int'(sum),        exp_sum);
        check({tag, ".finalcarry"}, int'(finalcarry), exp_carry);
        check({tag, ".err"},        int'(err),        exp_err);
        check({tag, ".out_valid"},  int'(out_valid),  exp_valid);
    endtask

    task automatic model_reset();
        exp_sum   = 0;
        exp_carry = 0;
        exp_err   = 0;
        exp_valid = 0;
    endtask

    // Decimal behaviour: operands are whole digits, the result is the total
    // split into units and tens; illegal digits give err with zero result.
    task automatic model_capture(input bit v, input int ta, input int tb_v, input int tc);
        int total;
        exp_valid = v ? 1 : 0;
        if (v) begin
            if (ta > 9 || tb_v > 9) begin
                exp_err   = 1;
                exp_sum   = 0;
                exp_carry = 0;
            end else begin
                total     = ta + tb_v + tc;
                exp_err   = 0;
                exp_sum   = total % 10;
                exp_carry = total / 10;
            end
        end
    endtask

    // Present operands, let one rising edge capture them, check #1 later.
    task automatic step(input bit v, input int ta, input int tb_v, input int tc, input string tag);
        in_valid = v;
        a        = 4'(ta);
        b        = 4'(tb_v);
        cin      = 1'(tc);
        @(posedge clk);
        #1;
        model_capture(v, ta, tb_v, tc);
        check_outputs(tag);
    endtask

    initial begin
        rst_n    = 1'b0;
        in_valid = 1'b0;
        a        = 4'd0;
        b        = 4'd0;
        cin      = 1'b0;
        model_reset();

        // Reset state
        #1;
        check_outputs("reset_initial");
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // No correction
        step(1'b1, 4, 5, 0, "add_4_5");
        // Correction boundaries
        step(1'b1, 5, 5, 0, "add_5_5");
        step(1'b1, 8, 8, 0, "add_8_8");
        step(1'b1, 9, 0, 1, "add_9_0_c1");
        // Maximum
        step(1'b1, 9, 9, 1, "add_9_9_c1");

        // Mid-stream asynchronous reset with a valid operand pair on the bus
        in_valid = 1'b1;
        a        = 4'd7;
        b        = 4'd8;
        cin      = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        check_outputs("reset_async");
        @(posedge clk);
        #1;
        check_outputs("reset_held_edge");
        @(negedge clk);
        rst_n = 1'b1;
        step(1'b1, 7, 8, 0, "after_reset_7_8");

        // Exhaustive sweep, back-to-back
        for (int ia = 0; ia < 10; ia++) begin
            for (int ib = 0; ib < 10; ib++) begin
                for (int ic = 0; ic < 2; ic++) begin
                    step(1'b1, ia, ib, ic, $sformatf("sweep_%0d_%0d_%0d", ia, ib, ic));
                end
            end
        end

        // Invalid operand, then hold, then a legal capture clears err
        step(1'b1, 10, 3, 0, "invalid_10_3");
        step(1'b0, 4, 4, 1, "hold_1");
        step(1'b0, 9, 9, 0, "hold_2");
        step(1'b0, 1, 2, 1, "hold_3");
        step(1'b1, 2, 3, 0, "legal_2_3");
        step(1'b1, 3, 15, 1, "invalid_3_15");
        step(1'b1, 15, 15, 1, "invalid_15_15");
        step(1'b1, 6, 7, 1, "legal_6_7_c1");

        // Randomized tail: mostly legal digits, occasional illegal ones,
        // in_valid gaps mixed in.
        for (int i = 0; i < 300; i++) begin
            int  ra;
            int  rb;
            int  rc;
            bit  rv;
            ra = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 15)) : int'($urandom_range(0, 9));
            rb = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 15)) : int'($urandom_range(0, 9));
            rc = int'($urandom_range(0, 1));
            rv = ($urandom_range(0, 3) != 0);
            step(rv, ra, rb, rc, $sformatf("rand_%0d", i));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
